// File: rtl/voice_mixer.sv
// voice_mixer: sequential voice mixer (average or saturating sum) with valid/ready output
module voice_mixer #(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   voices_in,
    input  logic [NUM_VOICES-1:0]                voice_active,
    input  logic                                 mode,
    input  logic                                 latch_in,
    output logic signed [SAMPLE_WIDTH-1:0]       mix_out,
    output logic                                 mix_valid,
    input  logic                                 mix_ready,
    output logic                                 busy,
    output logic                                 overrun
);
    localparam int CNT_W  = $clog2(NUM_VOICES + 1);
    localparam int ACC_W  = SAMPLE_WIDTH + CNT_W;
    localparam int STEP_W = $clog2(ACC_W);
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, NORM, HOLD} state_t;

    state_t                            state, state_d;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voices_q, voices_d;
    logic [NUM_VOICES-1:0]             mask_q, mask_d;
    logic                              mode_q, mode_d;
    logic signed [ACC_W-1:0]           acc, acc_d;
    logic [CNT_W-1:0]                  count, count_d, idx, idx_d;
    logic [STEP_W-1:0]                 step, step_d;
    logic [ACC_W-1:0]                  rem, rem_d;
    logic                              neg, neg_d;
    logic [SAMPLE_WIDTH-1:0]           mix_out_d;
    logic                              overrun_d;
    logic signed [SAMPLE_WIDTH-1:0]    cur;
    logic                              cur_act;
    logic [ACC_W:0]                    trial, div, diff;
    logic                              ge;
    logic [ACC_W-1:0]                  quo_next, rem_next, quo_signed;
    logic [SAMPLE_WIDTH-1:0]           sat;

    assign busy      = state != IDLE;
    assign mix_valid = state == HOLD;

    // Select the captured sample and enable bit addressed by idx
    always_comb begin
        cur     = '0;
        cur_act = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx == CNT_W'(i)) begin
                cur     = voices_q[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                cur_act = mask_q[i];
            end
        end
    end

    // One restoring-division step on the magnitude held in acc, plus the saturated sum
    always_comb begin
        trial      = {rem, acc[ACC_W-1]};
        div        = {{(ACC_W+1-CNT_W){1'b0}}, count};
        diff       = trial - div;
        ge         = trial >= div;
        rem_next   = ge ? diff[ACC_W-1:0] : trial[ACC_W-1:0];
        quo_next   = {acc[ACC_W-2:0], ge};
        quo_signed = neg ? -quo_next : quo_next;
        sat        = acc > SAT_HI ? SAT_HI[SAMPLE_WIDTH-1:0] : acc < SAT_LO ? SAT_LO[SAMPLE_WIDTH-1:0] : acc[SAMPLE_WIDTH-1:0];
    end

    // Next-state and datapath updates; latch requests outside IDLE only raise overrun
    always_comb begin
        state_d   = state;
        voices_d  = voices_q;
        mask_d    = mask_q;
        mode_d    = mode_q;
        acc_d     = acc;
        count_d   = count;
        idx_d     = idx;
        step_d    = step;
        rem_d     = rem;
        neg_d     = neg;
        mix_out_d = mix_out;
        overrun_d = latch_in && state != IDLE;
        case (state)
            IDLE: if (latch_in) begin
                voices_d = voices_in;
                mask_d   = voice_active;
                mode_d   = mode;
                acc_d    = '0;
                count_d  = '0;
                idx_d    = '0;
                state_d  = ACCUM;
            end
            ACCUM: if (idx != CNT_W'(NUM_VOICES)) begin
                if (cur_act) begin
                    acc_d   = acc + {{(ACC_W-SAMPLE_WIDTH){cur[SAMPLE_WIDTH-1]}}, cur};
                    count_d = count + CNT_W'(1);
                end
                idx_d = idx + CNT_W'(1);
            end else if (!mode_q && count > CNT_W'(1)) begin
                neg_d   = acc[ACC_W-1];
                acc_d   = acc[ACC_W-1] ? -acc : acc;
                rem_d   = '0;
                step_d  = '0;
                state_d = NORM;
            end else begin
                mix_out_d = sat;
                state_d   = HOLD;
            end
            NORM: begin
                acc_d  = quo_next;
                rem_d  = rem_next;
                step_d = step + STEP_W'(1);
                if (step == STEP_W'(ACC_W - 1)) begin
                    mix_out_d = quo_signed[SAMPLE_WIDTH-1:0];
                    state_d   = HOLD;
                end
            end
            HOLD: if (mix_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            voices_q <= '0;
            mask_q   <= '0;
            mode_q   <= 1'b0;
            acc      <= '0;
            count    <= '0;
            idx      <= '0;
            step     <= '0;
            rem      <= '0;
            neg      <= 1'b0;
            mix_out  <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_d;
            voices_q <= voices_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            acc      <= acc_d;
            count    <= count_d;
            idx      <= idx_d;
            step     <= step_d;
            rem      <= rem_d;
            neg      <= neg_d;
            mix_out  <= mix_out_d;
            overrun  <= overrun_d;
        end
    end
endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 Parameter NUM_VOICES, default 3: number of voice inputs mixed; legal range 1-16.
REQ-002 Parameter SAMPLE_WIDTH, default 16: width of each signed voice sample and of the mixed output.
REQ-003 Derived constant ACC_W = SAMPLE_WIDTH + ceil(log2(NUM_VOICES+1)), the accumulator width (18 at defaults); not overridable.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-006 voices_in  input  NUM_VOICES*SAMPLE_WIDTH  packed signed two's-complement samples; voice 0 occupies the LSBs.
REQ-007 voice_active  input  NUM_VOICES  per-voice enable; bit i set includes voice i in the mix.
REQ-008 mode  input  1  0 = average of the active voices, 1 = saturating sum.
REQ-009 latch_in  input  1  one-cycle pulse requesting capture of voices_in, voice_active and mode.
REQ-010 mix_out  output  SAMPLE_WIDTH  signed mixed result; registered.
REQ-011 mix_valid  output  1  high while mix_out holds an unconsumed result.
REQ-012 mix_ready  input  1  consumer accept; the transfer occurs on a cycle with mix_valid and mix_ready both high.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 overrun  output  1  one-cycle pulse when latch_in is dropped.

Function
REQ-015 The FSM SHALL have four states: IDLE, ACCUM, NORM and HOLD.
REQ-016 IDLE + latch_in: capture voices_in, voice_active and mode into internal registers; clear acc, count and idx; go to ACCUM.
REQ-017 ACCUM processes one voice per cycle for idx = 0..NUM_VOICES-1: if the captured active bit is set, acc += sign-extended sample and count += 1; then idx += 1.
REQ-018 After the last voice: go to NORM if mode=0 and count>=2, else go to HOLD.
REQ-019 NORM performs restoring division of |acc| by count, producing one quotient bit per cycle for exactly ACC_W cycles, then reapplies the sign and goes to HOLD.
REQ-020 Averaging result: truncate toward zero (e.g. -5/2 = -2).
REQ-021 Sum result (mode 1, or count = 1): saturate acc to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
REQ-022 count = 0: the result is 0 in either mode.
REQ-023 On entry to HOLD: mix_out is loaded and mix_valid asserted; the state remains HOLD until mix_ready, then returns to IDLE with mix_valid low on the following cycle.
REQ-024 Latency, with the latch edge as cycle 0: mix_valid rises at cycle NUM_VOICES+1 when NORM is skipped, and at cycle NUM_VOICES+1+ACC_W otherwise.
REQ-025 mix_out SHALL remain stable while mix_valid is high, and SHALL retain its last value after the handshake (never cleared, to avoid audible pops).
REQ-026 latch_in in any state other than IDLE, including HOLD in the same cycle as mix_ready, SHALL be ignored and SHALL pulse overrun for one cycle.
REQ-027 Changes to voices_in, voice_active or mode after capture SHALL NOT affect the result in progress.
REQ-028 mix_ready while mix_valid is low SHALL have no effect.

Reset
REQ-029 reset low: state = IDLE; mix_out = 0; mix_valid = 0; busy = 0; overrun = 0; acc, count and idx = 0.
REQ-030 reset asserted mid-operation SHALL abort that operation with no output; the first latch_in after release SHALL operate normally.

Verification (NUM_VOICES=3, SAMPLE_WIDTH=16, ACC_W=18)
REQ-031 mode=0, voices 300/600/900, mask 111 -> mix_out = 600; mix_valid rises at cycle 22; busy high for cycles 1-22.
REQ-032 mode=0, voices -7/2/0, mask 011 -> sum -5, count 2 -> mix_out = -2 (0xFFFE) at cycle 22.
REQ-033 mode=1, voices 30000/30000/-1000, mask 111 -> mix_out = 32767 at cycle 4; repeating with -30000/-30000/-1000 gives -32768.
REQ-034 mask 000 in either mode -> mix_out = 0 at cycle 4; mask 100, mode 0, voice2 = -123 -> mix_out = -123 at cycle 4, NORM skipped.
REQ-035 Backpressure: mix_ready held low 10 cycles in HOLD -> mix_out and mix_valid constant throughout; a latch_in pulse during ACCUM, NORM or HOLD -> overrun high exactly one cycle, result unchanged.
REQ-036 reset pulsed low during NORM -> all outputs 0 immediately; after release, mode=1, voices 1/2/3, mask 111 -> mix_out = 6 at cycle 4.
